// File: rtl/gauss_filter_ctrl.sv
// gauss_filter_ctrl: tap loader and bit upsampler/tail sequencer for the GFSK Gaussian filter
// Ports: cfg_we/cfg_addr/cfg_data write the 9-entry shadow tap bank; cfg_commit replays it
// on tap_index/tap_value (cfg_done follows tap 8). bit_in/_valid/_last/_ready is the packet
// bit stream; bit_upsample/_valid/_valid_last carry SAMPLE_PER_SYMBOL samples per bit plus
// TAIL_SAMPLES repeats of the last bit. busy is high outside IDLE.
module gauss_filter_ctrl #(
    parameter int GAUSS_FILTER_BIT_WIDTH = 16,
    parameter int SAMPLE_PER_SYMBOL      = 8,
    parameter int TAIL_SAMPLES           = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_we,
    input  logic [3:0]                        cfg_addr,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] cfg_data,
    input  logic                              cfg_commit,
    output logic                              cfg_done,
    output logic [3:0]                        tap_index,
    output logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
    input  logic                              bit_in,
    input  logic                              bit_in_valid,
    input  logic                              bit_in_last,
    output logic                              bit_in_ready,
    output logic                              bit_upsample,
    output logic                              bit_upsample_valid,
    output logic                              bit_upsample_valid_last,
    output logic                              busy
);
    localparam int W = GAUSS_FILTER_BIT_WIDTH;
    localparam logic [7:0] SPS_M1 = 8'(SAMPLE_PER_SYMBOL - 1);
    localparam logic [7:0] SPS_M2 = 8'(SAMPLE_PER_SYMBOL - 2);
    localparam logic [7:0] TAIL_M1 = 8'(TAIL_SAMPLES - 1);
    localparam logic [7:0] TAIL_M2 = 8'(TAIL_SAMPLES - 2);
    localparam bit TAIL_ZERO = (TAIL_SAMPLES == 0);
    localparam bit TAIL_ONE = (TAIL_SAMPLES == 1);
    localparam bit LAST_ON_FIRST = (SAMPLE_PER_SYMBOL == 1) && (TAIL_SAMPLES == 0);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, TAIL} state_t;
    state_t state, n_state;
    logic [W-1:0] shadow [0:8];
    logic [3:0] load_cnt, n_load_cnt, n_tap_index, load_inc;
    logic [W-1:0] n_tap_value;
    logic [7:0] samp_cnt, n_samp_cnt, tail_cnt, n_tail_cnt;
    logic have, n_have, cur_last, n_last, n_bit, n_valid, n_vlast, n_done, accept;
    // Commit wins over a bit offered in the same IDLE cycle, so ready drops for that cycle.
    always_comb
        bit_in_ready = (state == IDLE) ? !cfg_commit :
                       (state == RUN)  ? (!have || (samp_cnt == SPS_M1 && !cur_last)) : 1'b0;
    assign accept = bit_in_valid && bit_in_ready;
    assign load_inc = load_cnt + 4'd1;
    always_comb begin
        n_state = state;
        n_load_cnt = load_cnt;
        n_samp_cnt = samp_cnt;
        n_tail_cnt = tail_cnt;
        n_have = have;
        n_last = cur_last;
        n_bit = bit_upsample;
        n_valid = 1'b0;
        n_vlast = 1'b0;
        n_done = 1'b0;
        n_tap_index = 4'hF;
        n_tap_value = tap_value;
        if (accept) begin
            n_state = RUN;
            n_have = 1'b1;
            n_last = bit_in_last;
            n_bit = bit_in;
            n_samp_cnt = '0;
            n_valid = 1'b1;
            n_vlast = bit_in_last && LAST_ON_FIRST;
        end
        case (state)
            IDLE: if (cfg_commit) begin
                n_state = LOAD;
                n_load_cnt = '0;
                n_tap_index = '0;
                n_tap_value = shadow[0];
            end
            LOAD: if (load_cnt == 4'd8) begin
                n_state = IDLE;
                n_done = 1'b1;
            end else begin
                n_load_cnt = load_inc;
                n_tap_index = load_inc;
                n_tap_value = shadow[load_inc];
            end
            RUN: if (!accept && have) begin
                if (samp_cnt != SPS_M1) begin
                    n_samp_cnt = samp_cnt + 8'd1;
                    n_valid = 1'b1;
                    n_vlast = cur_last && TAIL_ZERO && samp_cnt == SPS_M2;
                end else begin
                    n_have = 1'b0;
                    // The last bit either ends the packet here or hands over to the tail.
                    if (cur_last) begin
                        n_state = TAIL_ZERO ? IDLE : TAIL;
                        n_tail_cnt = '0;
                        n_valid = !TAIL_ZERO;
                        n_vlast = TAIL_ONE;
                    end
                end
            end
            TAIL: if (tail_cnt == TAIL_M1) begin
                n_state = IDLE;
            end else begin
                n_tail_cnt = tail_cnt + 8'd1;
                n_valid = 1'b1;
                n_vlast = tail_cnt == TAIL_M2;
            end
            default: n_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            load_cnt <= '0;
            samp_cnt <= '0;
            tail_cnt <= '0;
            have <= 1'b0;
            cur_last <= 1'b0;
            bit_upsample <= 1'b0;
            bit_upsample_valid <= 1'b0;
            bit_upsample_valid_last <= 1'b0;
            cfg_done <= 1'b0;
            tap_index <= 4'hF;
            tap_value <= '0;
            busy <= 1'b0;
        end else begin
            state <= n_state;
            load_cnt <= n_load_cnt;
            samp_cnt <= n_samp_cnt;
            tail_cnt <= n_tail_cnt;
            have <= n_have;
            cur_last <= n_last;
            bit_upsample <= n_bit;
            bit_upsample_valid <= n_valid;
            bit_upsample_valid_last <= n_vlast;
            cfg_done <= n_done;
            tap_index <= n_tap_index;
            tap_value <= n_tap_value;
            busy <= n_state != IDLE;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) shadow[i] <= '0;
        end else if (cfg_we && cfg_addr <= 4'd8) begin
            shadow[cfg_addr] <= cfg_data;
        end
endmodule

// File: tb/tb_gauss_filter_ctrl.sv
// tb_gauss_filter_ctrl: directed bench with a sample scoreboard for gauss_filter_ctrl
module tb_gauss_filter_ctrl;
    localparam int W = 16;
    localparam int SPS = 8;
    localparam int TAILN = 16;
    typedef struct packed {logic b; logic l;} samp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cfg_we = 1'b0, cfg_commit = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [W-1:0] cfg_data = '0;
    logic cfg_done, bit_in_ready, bit_upsample, bit_upsample_valid, bit_upsample_valid_last, busy;
    logic [3:0] tap_index;
    logic [W-1:0] tap_value;
    logic bit_in = 1'b0, bit_in_valid = 1'b0, bit_in_last = 1'b0;
    samp_t q[$];
    int checks = 0, errors = 0, cyc = 0, run = 0, max_run = 0, vlast_n = 0, done_n = 0;
    int a0, a1, a2, c0;
    gauss_filter_ctrl #(.GAUSS_FILTER_BIT_WIDTH(W), .SAMPLE_PER_SYMBOL(SPS), .TAIL_SAMPLES(TAILN)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_done(cfg_done), .tap_index(tap_index), .tap_value(tap_value),
        .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_in_last(bit_in_last),
        .bit_in_ready(bit_in_ready), .bit_upsample(bit_upsample),
        .bit_upsample_valid(bit_upsample_valid), .bit_upsample_valid_last(bit_upsample_valid_last),
        .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_bit(input logic b, input logic l, output int acc);
        int n = 0;
        logic r;
        bit_in = b;
        bit_in_last = l;
        bit_in_valid = 1'b1;
        do begin
            #1;
            r = bit_in_ready;
            acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        check("accept_timeout", {31'b0, r}, 1);
        if (r) begin
            for (int i = 0; i < SPS; i++) q.push_back('{b: b, l: l && TAILN == 0 && i == SPS - 1});
            if (l) for (int i = 0; i < TAILN; i++) q.push_back('{b: b, l: i == TAILN - 1});
        end
    endtask
    task automatic idle_in();
        bit_in_valid = 1'b0;
        bit_in_last = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'b0, n < 200}, 1);
    endtask
    always @(negedge clk) if (rst_n) begin
        if (bit_upsample_valid) begin
            samp_t e;
            run++;
            if (run > max_run) max_run = run;
            check("sample_expected", {31'b0, q.size() != 0}, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sample_bit", bit_upsample, e.b);
                check("sample_last", bit_upsample_valid_last, e.l);
            end
            if (bit_upsample_valid_last) vlast_n++;
        end else begin
            run = 0;
            check("vlast_without_valid", bit_upsample_valid_last, 0);
        end
        if (cfg_done) done_n++;
    end
    initial begin
        tick();
        tick();
        check("rst_tap_index", tap_index, 4'hF);
        check("rst_tap_value", tap_value, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_bit_upsample", bit_upsample, 0);
        check("rst_valid", bit_upsample_valid, 0);
        check("rst_valid_last", bit_upsample_valid_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bit_in_ready, 1);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            cfg_we = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = W'(i + 1);
            tick();
        end
        cfg_we = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("load_tap_index", tap_index, i);
            check("load_tap_value", tap_value, i + 1);
            check("load_ready", bit_in_ready, 0);
            check("load_done_early", cfg_done, 0);
            tick();
        end
        check("load_done", cfg_done, 1);
        check("load_index_idle", tap_index, 4'hF);
        check("load_ready_after", bit_in_ready, 1);
        check("load_busy_after", busy, 0);
        tick();
        send_bit(1'b1, 1'b1, a0);
        idle_in();
        check("single_first_valid", bit_upsample_valid, 1);
        check("single_first_bit", bit_upsample, 1);
        repeat (22) tick();
        check("single_no_early_last", bit_upsample_valid_last, 0);
        tick();
        check("single_valid_last", bit_upsample_valid_last, 1);
        check("single_cycle", cyc - a0, 24);
        tick();
        check("single_busy_end", busy, 0);
        check("single_valid_end", bit_upsample_valid, 0);
        check("single_ready_end", bit_in_ready, 1);
        tick();
        max_run = 0;
        send_bit(1'b1, 1'b0, a0);
        send_bit(1'b0, 1'b0, a1);
        send_bit(1'b1, 1'b1, a2);
        idle_in();
        check("b2b_spacing1", a1 - a0, SPS);
        check("b2b_spacing2", a2 - a1, SPS);
        check("b2b_ready_held", bit_in_ready, 0);
        drain();
        check("b2b_contiguous", max_run, 3 * SPS + TAILN);
        tick();
        send_bit(1'b1, 1'b0, a0);
        idle_in();
        repeat (7) tick();
        check("gap_ready_end_sym", bit_in_ready, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("gap_valid_low", bit_upsample_valid, 0);
            check("gap_bit_hold", bit_upsample, 1);
            check("gap_ready_high", bit_in_ready, 1);
            if (k < 4) tick();
        end
        send_bit(1'b0, 1'b1, a1);
        idle_in();
        check("gap_accept_cycle", a1 - a0, SPS + 5);
        check("gap_resume_valid", bit_upsample_valid, 1);
        check("gap_resume_bit", bit_upsample, 0);
        drain();
        tick();
        send_bit(1'b0, 1'b1, a0);
        idle_in();
        tick();
        tick();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("run_commit_index", tap_index, 4'hF);
            check("run_commit_done", cfg_done, 0);
            tick();
        end
        drain();
        check("run_commit_idle_index", tap_index, 4'hF);
        tick();
        c0 = cyc;
        cfg_commit = 1'b1;
        bit_in = 1'b0;
        bit_in_last = 1'b1;
        bit_in_valid = 1'b1;
        #1;
        check("same_cycle_ready", bit_in_ready, 0);
        tick();
        cfg_commit = 1'b0;
        check("same_cycle_tap0", tap_index, 0);
        check("same_cycle_no_valid", bit_upsample_valid, 0);
        send_bit(1'b0, 1'b1, a0);
        idle_in();
        check("same_cycle_accept", a0 - c0, 10);
        check("same_cycle_valid", bit_upsample_valid, 1);
        drain();
        tick();
        send_bit(1'b1, 1'b1, a0);
        idle_in();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", bit_upsample_valid, 0);
        check("arst_valid_last", bit_upsample_valid_last, 0);
        check("arst_bit", bit_upsample, 0);
        check("arst_busy", busy, 0);
        check("arst_tap_index", tap_index, 4'hF);
        check("arst_ready", bit_in_ready, 1);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_bit(1'b0, 1'b1, a0);
        idle_in();
        check("post_rst_valid", bit_upsample_valid, 1);
        drain();
        tick();
        check("queue_empty", q.size(), 0);
        check("valid_last_count", vlast_n, 6);
        check("cfg_done_count", done_n, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
